pl_dmem_arb: RTL
================

PL_DMEM_ARB -- requirements
Module: pl_dmem_arb

Interface
REQ-001 SHALL have parameter NUM_DOMAINS, default 1, number of RNS domains (data width = NUM_DOMAINS*8).
REQ-002 SHALL have parameter ADDR_WID, default 16, data memory address width.
REQ-003 SHALL have parameter STARVE_LIM, default 4, denied host cycles before a forced host grant; range 1..15.
REQ-004 SHALL have port clk  in  1  single clock; all state updates on rising edge.
REQ-005 SHALL have port reset  in  1  synchronous, active-low reset.
REQ-006 SHALL have ports pl_st_en / pl_ld_en  in  1 each  pipeline store / load request from EX stage.
REQ-007 SHALL have port pl_inval  in  1  invalidate_execute_instr; masks both pipeline requests.
REQ-008 SHALL have ports pl_wr_addr / pl_rd_addr  in  ADDR_WID each  pipeline store / load address.
REQ-009 SHALL have port pl_wr_data  in  NUM_DOMAINS*8  pipeline store data.
REQ-010 SHALL have port pl_stall  out  1  pipeline access deferred this cycle; pipeline holds EX outputs.
REQ-011 SHALL have ports host_req, host_we  in  1 each; host_addr  in  ADDR_WID; host_wdata  in  NUM_DOMAINS*8.
REQ-012 SHALL have ports host_gnt  out  1; host_rvalid  out  1; host_rdata  out  NUM_DOMAINS*8.
REQ-013 SHALL have ports mem_en, mem_we  out  1 each; mem_addr  out  ADDR_WID; mem_wdata  out  NUM_DOMAINS*8; mem_rdata  in  NUM_DOMAINS*8.

Function
REQ-014 SHALL define pl_req = (pl_st_en | pl_ld_en) & !pl_inval.
REQ-015 SHALL select one owner per cycle, combinationally: FORCE (host, pipeline stalled) if force_host & host_req; else PL if pl_req; else HOST if host_req; else IDLE.
REQ-016 SHALL drive mem_en=1 for PL/HOST/FORCE owners, 0 in IDLE; mem_addr/mem_we/mem_wdata from the owner's inputs; zero in IDLE.
REQ-017 SHALL, when pl_st_en and pl_ld_en both set, perform the store (mem_we=1, pl_wr_addr) and ignore the load.
REQ-018 SHALL assert host_gnt combinationally for exactly the cycle the host access is presented on mem_*.
REQ-019 SHALL require host to hold host_req/addr/we/wdata stable until host_gnt; a request still high after gnt is a new request.
REQ-020 SHALL assert host_rvalid for one cycle, the cycle after a host read grant, with host_rdata = mem_rdata registered (1-cycle synchronous RAM).
REQ-021 SHALL hold host_rdata between reads; host_rvalid 0 otherwise.
REQ-022 SHALL keep a registered owner state (IDLE, PL, HOST, FORCE) recording last cycle's owner, used for rvalid generation.
REQ-023 SHALL assert pl_stall only when owner is FORCE and pl_req=1; pl_stall=0 otherwise, including when pl_inval=1.
REQ-024 SHALL not return load data; pipeline load data is taken from mem_rdata by the downstream stage.

Reset
REQ-025 SHALL, while reset=0 at a clock edge: owner state IDLE, starvation counter 0, host_rvalid 0, host_rdata 0.
REQ-026 SHALL gate combinational outputs during reset: mem_en=0, mem_we=0, host_gnt=0, pl_stall=0.
REQ-027 SHALL drop a pending host_rvalid if reset asserts the cycle after a host read grant.

Configuration
REQ-028 SHALL implement the starvation guard only when macro PL_DMEM_ARB_STARVE_GUARD_EN is defined.
REQ-029 SHALL, with the macro: 4-bit counter increments each cycle host_req=1 and host denied (owner PL), saturating at STARVE_LIM; force_host = (count == STARVE_LIM); counter clears on any host grant or host_req=0.
REQ-030 SHALL, without the macro: no counter, force_host=0, pl_stall tied 0, pipeline strict priority (host may starve).

Verification
REQ-031 SHALL test: host read addr 0x0010 alone, memory holds 0x5A -> host_gnt cycle 0, host_rvalid cycle 1, host_rdata=0x5A.
REQ-032 SHALL test: pl_st_en and host_req same cycle, STARVE_LIM=4 -> pipeline store granted, host_gnt=0, pl_stall=0.
REQ-033 SHALL test: pl_ld_en held 6 cycles with host_req high (guard on) -> PL cycles 0-3, cycle 4 FORCE: host_gnt=1, pl_stall=1; cycle 5 PL, counter 0.
REQ-034 SHALL test: pl_st_en=1, pl_inval=1, host_req=0 -> mem_en=0, pl_stall=0.
REQ-035 SHALL test: reset=0 asserted the cycle after host read grant -> host_rvalid stays 0, state IDLE.
REQ-036 SHALL test: guard off, pl_ld_en held 10 cycles with host_req -> host_gnt never 1, pl_stall never 1.

Source files
------------

// File: rtl/pl_dmem_arb.sv
// rtl/pl_dmem_arb.sv - data memory arbiter between EX-stage pipeline and host port; optional starvation guard via PL_DMEM_ARB_STARVE_GUARD_EN
module pl_dmem_arb #(
    parameter int NUM_DOMAINS = 1,
    parameter int ADDR_WID    = 16,
    parameter int STARVE_LIM  = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     pl_st_en,
    input  logic                     pl_ld_en,
    input  logic                     pl_inval,
    input  logic [ADDR_WID-1:0]      pl_wr_addr,
    input  logic [ADDR_WID-1:0]      pl_rd_addr,
    input  logic [NUM_DOMAINS*8-1:0] pl_wr_data,
    output logic                     pl_stall,
    input  logic                     host_req,
    input  logic                     host_we,
    input  logic [ADDR_WID-1:0]      host_addr,
    input  logic [NUM_DOMAINS*8-1:0] host_wdata,
    output logic                     host_gnt,
    output logic                     host_rvalid,
    output logic [NUM_DOMAINS*8-1:0] host_rdata,
    output logic                     mem_en,
    output logic                     mem_we,
    output logic [ADDR_WID-1:0]      mem_addr,
    output logic [NUM_DOMAINS*8-1:0] mem_wdata,
    input  logic [NUM_DOMAINS*8-1:0] mem_rdata
);

    localparam int DW = NUM_DOMAINS * 8;

    typedef enum logic [1:0] {
        OWN_IDLE  = 2'd0,
        OWN_PL    = 2'd1,
        OWN_HOST  = 2'd2,
        OWN_FORCE = 2'd3
    } owner_t;

    owner_t          owner_c;
    owner_t          owner_q;
    logic            host_rd_q;
    logic [DW-1:0]   rdata_q;
    logic            pl_req;
    logic            force_host;

    if (STARVE_LIM < 1 || STARVE_LIM > 15) begin : g_bad_lim
        $error("pl_dmem_arb: STARVE_LIM must be within 1..15");
    end

    // An invalidated EX instruction must not touch memory.
    assign pl_req = (pl_st_en | pl_ld_en) & ~pl_inval;

`ifdef PL_DMEM_ARB_STARVE_GUARD_EN
    localparam logic [3:0] LIM = 4'(STARVE_LIM);
    logic [3:0] starve_cnt;

    // Count consecutive cycles the host loses to the pipeline; saturate at the limit.
    always_ff @(posedge clk) begin
        if (!reset) begin
            starve_cnt <= 4'd0;
        end else if (!host_req || host_gnt) begin
            starve_cnt <= 4'd0;
        end else if (owner_c == OWN_PL && starve_cnt != LIM) begin
            starve_cnt <= starve_cnt + 4'd1;
        end
    end

    assign force_host = (starve_cnt == LIM);
    assign pl_stall   = (owner_c == OWN_FORCE) & pl_req;
`else
    assign force_host = 1'b0;
    assign pl_stall   = 1'b0;
`endif

    // Owner selection: forced host first, then pipeline, then host; idle in reset.
    always_comb begin
        owner_c = OWN_IDLE;
        if (!reset) begin
            owner_c = OWN_IDLE;
        end else if (force_host && host_req) begin
            owner_c = OWN_FORCE;
        end else if (pl_req) begin
            owner_c = OWN_PL;
        end else if (host_req) begin
            owner_c = OWN_HOST;
        end
    end

    // Steer the owner's request onto the memory port; a store wins over a simultaneous load.
    always_comb begin
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        case (owner_c)
            OWN_PL: begin
                mem_en    = 1'b1;
                mem_we    = pl_st_en;
                mem_addr  = pl_st_en ? pl_wr_addr : pl_rd_addr;
                mem_wdata = pl_st_en ? pl_wr_data : '0;
            end
            OWN_HOST, OWN_FORCE: begin
                mem_en    = 1'b1;
                mem_we    = host_we;
                mem_addr  = host_addr;
                mem_wdata = host_wdata;
            end
            default: begin
                mem_en    = 1'b0;
            end
        endcase
    end

    assign host_gnt = (owner_c == OWN_HOST) || (owner_c == OWN_FORCE);

    // Read data arrives from the RAM the cycle after the grant; reset drops it.
    assign host_rvalid = reset & host_rd_q & ((owner_q == OWN_HOST) || (owner_q == OWN_FORCE));
    assign host_rdata  = host_rvalid ? mem_rdata : rdata_q;

    // Record last cycle's owner and hold the most recent host read data.
    always_ff @(posedge clk) begin
        if (!reset) begin
            owner_q   <= OWN_IDLE;
            host_rd_q <= 1'b0;
            rdata_q   <= '0;
        end else begin
            owner_q   <= owner_c;
            host_rd_q <= host_gnt & ~host_we;
            if (host_rvalid) begin
                rdata_q <= mem_rdata;
            end
        end
    end

endmodule
